// File: rtl/i2c_rx_pkg.sv
// Shared widths, reload constant and edge-detect helpers for the I2C receive datapath.
package i2c_rx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 7;

    localparam logic [2:0] RI_RELOAD = 3'd7;

    // Current and previous registered sample of a level, used for rising-edge detection.
    typedef struct packed {
        logic cur;
        logic prev;
    } rise_t;

    function automatic logic rose(input rise_t e);
        return e.cur & ~e.prev;
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for an asynchronous line, followed by a registered rising-edge detect.
module i2c_sync_edge
    import i2c_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic  meta_q;
    rise_t edge_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= 1'b0;
            edge_q.cur  <= 1'b0;
            edge_q.prev <= 1'b0;
        end else begin
            meta_q      <= d;
            edge_q.cur  <= meta_q;
            edge_q.prev <= edge_q.cur;
        end
    end

    assign q    = edge_q.cur;
    assign rise = rose(edge_q);

endmodule

// File: rtl/i2c_rx_datapath.sv
// I2C receive datapath: bit shifting, bit/byte counting, ping-pong byte buffers and host hand-off.
module i2c_rx_datapath
    import i2c_rx_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StartRX,
    input  logic [CNT_W-1:0]  RXLen,
    input  logic              SCLIn,
    input  logic              SDAIn,
    input  logic              LatchRXD0,
    input  logic              LatchRXD1,
    input  logic              DecRXCount,
    input  logic              ValidRXDout,
    output logic              ValidRXDIn,
    output logic [2:0]        RIcount,
    output logic [CNT_W-1:0]  RXcount,
    output logic [DATA_W-1:0] RXD0,
    output logic [DATA_W-1:0] RXD1,
    output logic [DATA_W-1:0] RXData,
    output logic              RXStrobe,
    output logic              Overrun
);

    logic scl_rise;
    logic sda_sync;

    i2c_sync_edge u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SCLIn),
        .q     (),
        .rise  (scl_rise)
    );

    i2c_sync_edge u_sda_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (SDAIn),
        .q     (sda_sync),
        .rise  ()
    );

    // Controller strobes are levels; only their registered rising edges act.
    rise_t start_q, lat0_q, lat1_q, dec_q, vout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= '0;
            lat0_q  <= '0;
            lat1_q  <= '0;
            dec_q   <= '0;
            vout_q  <= '0;
        end else begin
            start_q <= '{cur: StartRX,     prev: start_q.cur};
            lat0_q  <= '{cur: LatchRXD0,   prev: lat0_q.cur};
            lat1_q  <= '{cur: LatchRXD1,   prev: lat1_q.cur};
            dec_q   <= '{cur: DecRXCount,  prev: dec_q.cur};
            vout_q  <= '{cur: ValidRXDout, prev: vout_q.cur};
        end
    end

    logic start_rise, start_active;
    logic lat0_rise, lat1_rise, dec_rise, vout_rise;

    assign start_rise   = rose(start_q);
    assign start_active = start_q.cur;
    assign lat0_rise    = rose(lat0_q);
    assign lat1_rise    = rose(lat1_q);
    assign dec_rise     = rose(dec_q);
    assign vout_rise    = rose(vout_q);

    logic [DATA_W-1:0] shift_q,   shift_d;
    logic [2:0]        ri_q,      ri_d;
    logic              ack_q,     ack_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;
    logic              sel_q,     sel_d;
    logic [DATA_W-1:0] rxd0_q,    rxd0_d;
    logic [DATA_W-1:0] rxd1_q,    rxd1_d;
    logic [CNT_W-1:0]  rxcount_q, rxcount_d;
    logic [DATA_W-1:0] rxdata_q,  rxdata_d;
    logic              strobe_q,  strobe_d;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        shift_d   = shift_q;
        ri_d      = ri_q;
        ack_d     = ack_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        sel_d     = sel_q;
        rxd0_d    = rxd0_q;
        rxd1_d    = rxd1_q;
        rxcount_d = rxcount_q;
        rxdata_d  = rxdata_q;
        strobe_d  = 1'b0;

        if (start_rise) begin
            rxcount_d = RXLen;
            overrun_d = 1'b0;
            valid_d   = 1'b0;
            ack_d     = 1'b0;
            sel_d     = 1'b0;
            ri_d      = RI_RELOAD;
        end else if (!start_active) begin
            ri_d    = RI_RELOAD;
            shift_d = '0;
            ack_d   = 1'b0;
        end else begin
            // Latches capture the pre-sample shift value; a completing byte below overrides the clear.
            if (lat0_rise) begin
                rxd0_d  = shift_q;
                valid_d = 1'b0;
                sel_d   = 1'b0;
            end else if (lat1_rise) begin
                rxd1_d  = shift_q;
                valid_d = 1'b0;
                sel_d   = 1'b1;
            end

            if (dec_rise && (rxcount_q != '0)) begin
                rxcount_d = rxcount_q - CNT_W'(1);
            end

            if (scl_rise) begin
                if (ack_q) begin
                    ack_d = 1'b0;
                end else begin
                    shift_d = {shift_q[DATA_W-2:0], sda_sync};
                    if (ri_q != 3'd0) begin
                        ri_d = ri_q - 3'd1;
                    end else begin
                        ri_d    = RI_RELOAD;
                        ack_d   = 1'b1;
                        valid_d = 1'b1;
                        if (valid_q) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
        end

        if (vout_rise) begin
            rxdata_d = sel_q ? rxd1_q : rxd0_q;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            ri_q      <= RI_RELOAD;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            sel_q     <= 1'b0;
            rxd0_q    <= '0;
            rxd1_q    <= '0;
            rxcount_q <= '0;
            rxdata_q  <= '0;
            strobe_q  <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            ri_q      <= ri_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            sel_q     <= sel_d;
            rxd0_q    <= rxd0_d;
            rxd1_q    <= rxd1_d;
            rxcount_q <= rxcount_d;
            rxdata_q  <= rxdata_d;
            strobe_q  <= strobe_d;
        end
    end

    assign ValidRXDIn = valid_q;
    assign RIcount    = ri_q;
    assign RXcount    = rxcount_q;
    assign RXD0       = rxd0_q;
    assign RXD1       = rxd1_q;
    assign RXData     = rxdata_q;
    assign RXStrobe   = strobe_q;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_i2c_rx_datapath.sv
// Self-checking bench for i2c_rx_datapath: bit-level bus stimulus with a scoreboard on host output.
module tb_i2c_rx_datapath;
    import i2c_rx_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              StartRX, SCLIn, SDAIn;
    logic [CNT_W-1:0]  RXLen;
    logic              LatchRXD0, LatchRXD1, DecRXCount, ValidRXDout;
    logic              ValidRXDIn, RXStrobe, Overrun;
    logic [2:0]        RIcount;
    logic [CNT_W-1:0]  RXcount;
    logic [DATA_W-1:0] RXD0, RXD1, RXData;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] sb_q[$];
    int strobe_w = 0;

    always #5 clk = ~clk;

    i2c_rx_datapath dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StartRX     (StartRX),
        .RXLen       (RXLen),
        .SCLIn       (SCLIn),
        .SDAIn       (SDAIn),
        .LatchRXD0   (LatchRXD0),
        .LatchRXD1   (LatchRXD1),
        .DecRXCount  (DecRXCount),
        .ValidRXDout (ValidRXDout),
        .ValidRXDIn  (ValidRXDIn),
        .RIcount     (RIcount),
        .RXcount     (RXcount),
        .RXD0        (RXD0),
        .RXD1        (RXD1),
        .RXData      (RXData),
        .RXStrobe    (RXStrobe),
        .Overrun     (Overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Host-side monitor: pops the expected byte on each strobe and checks the pulse width.
    always @(negedge clk) begin
        if (rst_n) begin
            if (RXStrobe) begin
                if (strobe_w == 0) begin
                    if (sb_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                    else check("rxdata", RXData, sb_q.pop_front());
                end
                strobe_w++;
            end else if (strobe_w != 0) begin
                check("strobe_width", strobe_w, 1);
                strobe_w = 0;
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic ack_slot, input logic latch1_at_sample);
        SDAIn = b;
        wait_n(5);
        SCLIn = 1'b1;
        if (latch1_at_sample) begin
            // One cycle later than SCL so both edges land on the same clock.
            wait_n(1);
            LatchRXD1 = 1'b1;
            wait_n(2);
            LatchRXD1 = 1'b0;
            wait_n(2);
        end else begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (ack_slot) check("ri_in_ack", RIcount, 3'd7);
            end
        end
        SCLIn = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
    endtask

    task automatic strobe(input int which, input int hold);
        @(negedge clk);
        case (which)
            0: LatchRXD0 = 1'b1;
            1: LatchRXD1 = 1'b1;
            2: DecRXCount = 1'b1;
            default: ValidRXDout = 1'b1;
        endcase
        wait_n(hold);
        LatchRXD0 = 1'b0;
        LatchRXD1 = 1'b0;
        DecRXCount = 1'b0;
        ValidRXDout = 1'b0;
        wait_n(3);
    endtask

    task automatic restart(input logic [CNT_W-1:0] len);
        @(negedge clk);
        StartRX = 1'b0;
        wait_n(3);
        RXLen = len;
        StartRX = 1'b1;
        wait_n(3);
    endtask

    initial begin
        rst_n = 1'b0;
        StartRX = 1'b0; RXLen = '0; SCLIn = 1'b0; SDAIn = 1'b1;
        LatchRXD0 = 1'b0; LatchRXD1 = 1'b0; DecRXCount = 1'b0; ValidRXDout = 1'b0;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(2);

        check("rst_ricount", RIcount, 3'd7);
        check("rst_rxcount", RXcount, 0);
        check("rst_valid", ValidRXDIn, 0);
        check("rst_rxd0", RXD0, 0);
        check("rst_rxd1", RXD1, 0);
        check("rst_rxdata", RXData, 0);
        check("rst_strobe", RXStrobe, 0);
        check("rst_overrun", Overrun, 0);

        // Overrun: two bytes with no latch in between.
        restart(7'd2);
        check("start_rxcount", RXcount, 2);
        send_byte(8'h11);
        check("ovr_valid_first", ValidRXDIn, 1);
        check("ovr_not_yet", Overrun, 0);
        send_byte(8'h22);
        check("ovr_flag", Overrun, 1);
        check("ovr_valid", ValidRXDIn, 1);
        check("ovr_rxd0", RXD0, 0);
        check("ovr_rxd1", RXD1, 0);
        restart(7'd2);
        check("ovr_cleared", Overrun, 0);
        check("ovr_valid_cleared", ValidRXDIn, 0);

        // Two-byte receive with ack slots and ping-pong latching.
        send_byte(8'hA5);
        check("b0_valid", ValidRXDIn, 1);
        strobe(0, 2);
        check("b0_rxd0", RXD0, 8'hA5);
        check("b0_valid_clr", ValidRXDIn, 0);
        strobe(2, 1);
        check("b0_rxcount", RXcount, 1);
        send_byte(8'h3C);
        strobe(1, 2);
        check("b1_rxd1", RXD1, 8'h3C);
        check("b1_rxd0_kept", RXD0, 8'hA5);
        strobe(2, 1);
        check("b1_rxcount", RXcount, 0);
        check("b1_overrun", Overrun, 0);

        // Held ValidRXDout: one strobe carrying the last latched buffer.
        sb_q.push_back(8'h3C);
        strobe(3, 5);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drain_1", sb_q.size(), 0);

        // Held DecRXCount.
        restart(7'd2);
        strobe(2, 10);
        check("held_dec_2", RXcount, 1);
        strobe(2, 1);
        check("redec_0", RXcount, 0);
        strobe(2, 1);
        check("sat_0", RXcount, 0);
        restart(7'd1);
        strobe(2, 10);
        check("held_dec_1", RXcount, 0);

        // Byte completes in the same cycle as a LatchRXD1 edge; shift starts cleared, so prior = 0x96 >> 1.
        restart(7'd3);
        for (int i = 7; i >= 1; i--) send_bit(8'h96 >> i, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        wait_n(2);
        check("simul_rxd1", RXD1, 8'h4B);
        check("simul_valid", ValidRXDIn, 1);
        send_bit(1'b0, 1'b1, 1'b0);
        sb_q.push_back(8'h4B);
        strobe(3, 2);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("sb_drain_2", sb_q.size(), 0);

        // Abort after four bits.
        restart(7'd4);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        wait_n(2);
        check("abort_ri_mid", RIcount, 3);
        @(negedge clk);
        StartRX = 1'b0;
        wait_n(3);
        check("abort_ri", RIcount, 3'd7);
        StartRX = 1'b1;
        wait_n(3);
        strobe(0, 1);
        check("abort_shift_clr", RXD0, 0);

        // Asynchronous reset mid-byte.
        restart(7'd5);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        wait_n(2);
        check("pre_rst_ri", RIcount, 3'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ricount", RIcount, 3'd7);
        check("arst_rxcount", RXcount, 0);
        check("arst_rxd1", RXD1, 0);
        check("arst_rxdata", RXData, 0);
        check("arst_valid", ValidRXDIn, 0);
        check("arst_overrun", Overrun, 0);
        check("sb_final", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_rx_datapath.md
# i2c_rx_datapath

Receive datapath for the I2C receive path. It synchronises SCL/SDA, shifts serial bits MSB-first into a byte, and tracks the bit and byte counts. It double-buffers completed bytes into two ping-pong registers under the receive controller's latch strobes, then presents each validated byte to the host. It sits directly downstream of the line pins and feeds the receive controller its status: `ValidRXDIn`, `RIcount` and `RXcount`.

## Interface
- `DATA_W`, 8, byte width.
- `CNT_W`, 7, byte-count width.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `StartRX` in 1: receive enable; its rising edge starts a transfer.
- `RXLen` in CNT_W: bytes to receive; sampled on the `StartRX` rising edge.
- `SCLIn`, `SDAIn` in 1: raw bus lines, asynchronous.
- `LatchRXD0`, `LatchRXD1`, `DecRXCount`, `ValidRXDout` in 1: controller strobes. These are levels, possibly held for several cycles.
- `ValidRXDIn` out 1: an assembled byte is waiting to be latched.
- `RIcount` out 3: bits still to receive in the current byte, 7..0.
- `RXcount` out CNT_W: bytes remaining.
- `RXD0`, `RXD1` out DATA_W: ping-pong byte buffers.
- `RXData` out DATA_W: byte to the host.
- `RXStrobe` out 1: one-cycle pulse; `RXData` is valid in that cycle.
- `Overrun` out 1: sticky error flag.

## Operation
- **Reset values.** All outputs are 0 except `RIcount`=7. The shift register, ack flag and ping-pong selector are all 0.
- **Synchronisation.** SCL and SDA each pass through a 2-flop synchroniser. An SCL rising edge is detected from the synchronised value against its previous value.
- **Edge-based strobes.** Every controller strobe acts on its rising edge only, detected by a registered compare. Holding a strobe high has no further effect.
- **Idle (`StartRX`=0).** No sampling. `RIcount` is held at 7, the shift register and ack flag are cleared, and `RXD0`/`RXD1`/`RXcount` are held.
- **Start (`StartRX` rising edge).** `RXcount`←`RXLen`. `Overrun`, `ValidRXDIn`, the ack flag and the selector are cleared. `RIcount`←7.
- **Bit sample (`StartRX`=1, SCL rising edge, ack flag clear).**
  - shift←{shift[DATA_W-2:0], SDA}.
  - If `RIcount`≠0: `RIcount` decrements.
  - If `RIcount`=0 (byte complete): `RIcount`←7, set the ack flag, set `ValidRXDIn`. If `ValidRXDIn` was already 1, set `Overrun`; the buffers are untouched.
- **Ack slot (SCL rising edge, ack flag set).** The sample is discarded; the shift register and `RIcount` are unchanged. The ack flag clears.
- **`LatchRXD0` / `LatchRXD1` rising edge.** `RXD0` (or `RXD1`) ← shift register, clear `ValidRXDIn`, selector←0 (or 1).
  - Both latch edges in the same cycle: `RXD0` only is loaded.
  - Byte completion in the same cycle as a latch edge: the latch captures the pre-update shift value, and set beats clear, so `ValidRXDIn` ends at 1.
- **`DecRXCount` rising edge.** `RXcount` decrements, saturating at 0.
- **`ValidRXDout` rising edge.** `RXData`←(selector ? `RXD1` : `RXD0`), and `RXStrobe` pulses for one cycle.
- **`Overrun`.** Sticky; cleared only by reset or a `StartRX` rising edge.

## Timing
- **SCL edge to sample.** The sample takes effect 3 `clk` cycles after an SCL transition at the pin: 2 synchroniser stages plus the edge register. SDA is delayed by the same amount, so it is sampled aligned with SCL.
- **Strobe latency.** Each controller strobe edge has a 1-cycle edge-detect register. The resulting update is visible 1 cycle after the edge is registered.
- **`ValidRXDIn`.** Goes to 1 in the cycle after the 8th data sample.
- **`RXStrobe`.** Goes high 2 cycles after `ValidRXDout` rises at the input.
- **Precondition.** SCL must stay high or low for at least 4 `clk` cycles.
- **Reset.** Asserting `rst_n` mid-byte returns every register to its reset value immediately (asynchronous). Deassertion is synchronised externally.

## Structure
- **Package `i2c_rx_pkg`:** `DATA_W`, `CNT_W`, `RI_RELOAD`=3'd7, and a `rise_t` helper typedef for edge-detect pairs.
- **Sub-module `i2c_sync_edge`:** 2-flop synchroniser plus rising-edge detector, with ports `clk`, `rst_n`, `d`, `q`, `rise`. It is instantiated for SCL (using `rise`) and for SDA (using `q` only).
- The remaining logic stays in a single module. The controller-strobe edge detects are plain registers.

## Test plan
- **Two-byte receive.** `RXLen`=2; drive bytes 0xA5 then 0x3C with ack slots; pulse `LatchRXD0` after the first byte and `LatchRXD1` after the second; raise `DecRXCount` twice.
  - Required: `RXD0`=0xA5, `RXD1`=0x3C, `RXcount` goes 2→1→0, `Overrun`=0.
- **Ack slot skipped.** Hold SDA low during each 9th SCL pulse.
  - Required: the next byte is still 0x3C, and `RIcount` reads 7 throughout the ack slot.
- **Overrun.** Receive two bytes with no latch strobe.
  - Required: `Overrun`=1, `ValidRXDIn`=1, `RXD0`/`RXD1` still 0. A `StartRX` re-rise clears `Overrun`.
- **Held strobes.** Hold `DecRXCount` high for 10 cycles with `RXcount`=1, then re-pulse it.
  - Required: `RXcount`=0 and stays 0. `RXStrobe` is exactly 1 cycle wide for a `ValidRXDout` held 5 cycles, with `RXData` equal to the last latched buffer.
- **Simultaneous completion and latch.** A byte completes in the same cycle as a `LatchRXD1` edge.
  - Required: `RXD1` holds the prior shift value and `ValidRXDIn`=1.
- **Abort and reset mid-byte.**
  - Drop `StartRX` after 4 bits: `RIcount`=7 and the shift register is cleared.
  - Assert `rst_n` low mid-byte: all outputs go to their reset values within the same cycle.
